// File: rtl/trivium_pkg.sv
// Shared Trivium constants: register widths, 1-based tap positions, FSM state type.
`timescale 1ns/1ps
package trivium_pkg;

  localparam int STATE_W = 288;
  localparam int KEY_W   = 80;
  localparam int IV_W    = 80;

  // Tap positions use the cipher's 1-based bit numbering (s1..s288).
  localparam int T1_X = 66;
  localparam int T1_Y = 93;
  localparam int T1_A = 91;
  localparam int T1_B = 92;
  localparam int T1_C = 171;
  localparam int T2_X = 162;
  localparam int T2_Y = 177;
  localparam int T2_A = 175;
  localparam int T2_B = 176;
  localparam int T2_C = 264;
  localparam int T3_X = 243;
  localparam int T3_Y = 288;
  localparam int T3_A = 286;
  localparam int T3_B = 287;
  localparam int T3_C = 69;

  typedef enum logic [1:0] {LOAD, INIT, GEN, DONE} fsm_t;

  // Map 1-based cipher bit number n onto the 0-based state vector.
  function automatic logic sbit(input logic [STATE_W-1:0] s, input int n);
    return s[n-1];
  endfunction

endpackage

// File: rtl/trivium_core.sv
// Trivium 288-bit state register with load/advance control; z is combinational
// from the current state.
`timescale 1ns/1ps
module trivium_core
  import trivium_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic            z
);

  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] nxt;
  logic t1, t2, t3;
  logic f1, f2, f3;

  always_comb begin
    t1 = sbit(st, T1_X) ^ sbit(st, T1_Y);
    t2 = sbit(st, T2_X) ^ sbit(st, T2_Y);
    t3 = sbit(st, T3_X) ^ sbit(st, T3_Y);
    z  = t1 ^ t2 ^ t3;
    f1 = t1 ^ (sbit(st, T1_A) & sbit(st, T1_B)) ^ sbit(st, T1_C);
    f2 = t2 ^ (sbit(st, T2_A) & sbit(st, T2_B)) ^ sbit(st, T2_C);
    f3 = t3 ^ (sbit(st, T3_A) & sbit(st, T3_B)) ^ sbit(st, T3_C);
    // One global shift, then overwrite the head of each of the three registers.
    nxt      = {st[STATE_W-2:0], 1'b0};
    nxt[0]   = f3;
    nxt[93]  = f1;
    nxt[177] = f2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
    end else if (load) begin
      st <= {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
    end else if (en) begin
      st <= nxt;
    end
  end

endmodule

// File: rtl/trivium_uut.sv
// Trivium unit under test: LOAD -> INIT warm-up -> GEN keystream -> DONE.
// Optional TRIVIUM_UUT_CYCLE_CNT_EN adds a 32-bit latency counter output.
`timescale 1ns/1ps
module trivium_uut
  import trivium_pkg::*;
#(
  parameter int OUTPUT_SIZE = 64,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       key_i,
  input  logic [IV_W-1:0]        iv_i,
  output logic [OUTPUT_SIZE-1:0] keystream_o,
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
  output logic [31:0]            cycle_cnt_o,
`endif
  output logic                   end_o
);

  localparam int MAX_N = (INIT_ROUNDS > OUTPUT_SIZE) ? INIT_ROUNDS : OUTPUT_SIZE;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'((INIT_ROUNDS > 0) ? INIT_ROUNDS - 1 : 0);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(OUTPUT_SIZE - 1);

  fsm_t                   state;
  logic [CNT_W-1:0]       cnt;
  logic                   z;
  logic [OUTPUT_SIZE-1:0] ks_next;

  trivium_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (state == LOAD),
    .en   ((state == INIT) || (state == GEN)),
    .key  (key_i),
    .iv   (iv_i),
    .z    (z)
  );

  // First keystream bit must end up in the MSB, so shift in at the LSB.
  if (OUTPUT_SIZE > 1) begin : g_shift
    assign ks_next = {keystream_o[OUTPUT_SIZE-2:0], z};
  end else begin : g_single
    assign ks_next = z;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      keystream_o <= '0;
      end_o       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          cnt   <= '0;
          state <= (INIT_ROUNDS == 0) ? GEN : INIT;
        end
        INIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            state <= GEN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GEN: begin
          keystream_o <= ks_next;
          if (cnt == GEN_LAST) begin
            cnt   <= '0;
            state <= DONE;
            end_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
  // Counts LOAD through the final GEN cycle, then freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_o <= '0;
    end else if (state != DONE) begin
      cycle_cnt_o <= cycle_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trivium_uut.sv
// Scoreboard bench for trivium_uut: a default-parameter DUT and an INIT_ROUNDS=0 DUT
// checked against a bit-array Trivium reference model.
`timescale 1ns/1ps
module tb_trivium_uut;

  typedef struct {
    logic [63:0] w;
    int          e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [79:0] key;
  logic [79:0] iv;
  logic [63:0] ks;
  logic [63:0] ks0;
  logic        end_m;
  logic        end0;
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
  logic [31:0] cyc;
  logic [31:0] cyc0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;
  exp_t q[$];
  exp_t q0[$];

  trivium_uut dut (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key),
    .iv_i        (iv),
    .keystream_o (ks),
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
    .cycle_cnt_o (cyc),
`endif
    .end_o       (end_m)
  );

  trivium_uut #(.OUTPUT_SIZE(64), .INIT_ROUNDS(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key),
    .iv_i        (iv),
    .keystream_o (ks0),
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
    .cycle_cnt_o (cyc0),
`endif
    .end_o       (end0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 1-based bit array s[1..288], stepped exactly as the cipher rules read.
  function automatic logic [63:0] ref_ks(input logic [79:0] k, input logic [79:0] v, input int rounds);
    bit s[1:288];
    bit t1, t2, t3, zz;
    logic [63:0] w;
    w = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int r = 0; r < rounds + 64; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      zz = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1]   = t3;
      s[94]  = t1;
      s[178] = t2;
      if (r >= rounds) w = {w[62:0], zz};
    end
    return w;
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard on each end_o rise, then checks the word stays held.
  initial begin
    logic [63:0] held, held0;
    logic        end_q, end0_q;
    exp_t        e;
    end_q  = 1'b0;
    end0_q = 1'b0;
    held   = '0;
    held0  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (end_m && !end_q) begin
          if (q.size() == 0) begin
            chk("unexpected_end", 64'(end_m), 64'(0));
          end else begin
            e = q.pop_front();
            chk("keystream", ks, e.w);
            chk("end_edge", 64'(edge_cnt), 64'(e.e));
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
            chk("cycle_cnt", 64'(cyc), 64'(1217));
`endif
            held = ks;
          end
        end else if (end_m) begin
          chk("hold", ks, held);
`ifdef TRIVIUM_UUT_CYCLE_CNT_EN
          chk("cycle_cnt_hold", 64'(cyc), 64'(1217));
`endif
        end
        if (end0 && !end0_q) begin
          if (q0.size() == 0) begin
            chk("unexpected_end0", 64'(end0), 64'(0));
          end else begin
            e = q0.pop_front();
            chk("keystream0", ks0, e.w);
            chk("end_edge0", 64'(edge_cnt), 64'(e.e));
            held0 = ks0;
          end
        end else if (end0) begin
          chk("hold0", ks0, held0);
        end
      end
      end_q  = end_m;
      end0_q = end0;
    end
  end

  // Reset, push expectations, release and wait (bounded) for the main DUT to finish.
  task automatic run(input logic [79:0] k, input logic [79:0] v, input bit chg, input int hold);
    int n;
    rst = 1'b1;
    key = k;
    iv  = v;
    @(negedge clk);
    chk("rst_end", 64'(end_m), 64'(0));
    chk("rst_ks", ks, 64'(0));
    q.push_back('{ref_ks(k, v, 1152), 1217});
    q0.push_back('{ref_ks(k, v, 0), 65});
    rst = 1'b0;
    n = 0;
    while (!end_m && n < 1300) begin
      @(negedge clk);
      n++;
      if (chg && n == 10) begin
        key = rand80();
        iv  = rand80();
      end
    end
    chk("end_timeout", 64'(end_m), 64'(1));
    if (!end_m) q.delete();
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    logic [79:0] rk, rv;
    rst = 1'b1;
    key = '0;
    iv  = '0;
    repeat (3) @(negedge clk);

    run('0, '0, 1'b0, 100);
    chk("zero_nibble", 64'(ks0[63:60]), 64'(4'hE));

    // Reset while in DONE must clear outputs without waiting for a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_end", 64'(end_m), 64'(0));
    chk("async_ks", ks, 64'(0));
    chk("async_ks0", ks0, 64'(0));

    rk = rand80();
    rv = rand80();
    run(rk, rv, 1'b1, 5);

    // Abort mid-INIT, then rerun the same key/iv from a fresh release.
    rk  = rand80();
    rv  = rand80();
    rst = 1'b1;
    key = rk;
    iv  = rv;
    @(negedge clk);
    q0.push_back('{ref_ks(rk, rv, 0), 65});
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midinit_end", 64'(end_m), 64'(0));
    chk("midinit_ks0", ks0, 64'(0));
    run(rk, rv, 1'b0, 5);

    for (int i = 0; i < 50; i++) begin
      run(rand80(), rand80(), 1'b0, 2);
    end

    chk("q_empty", 64'(q.size()), 64'(0));
    chk("q0_empty", 64'(q0.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trivium_uut.md
# trivium_uut

Trivium stream-cipher unit under test for the hardware autotest flow. It accepts the 80-bit key and 80-bit IV driven by the autotest controller and runs the Trivium initialisation rounds. It then produces an OUTPUT_SIZE-bit keystream word and raises a done flag that the controller polls before writing results to SD. It sits directly downstream of the autotest controller's UUT control and parameter outputs and feeds its result and done inputs.

## Interface
- OUTPUT_SIZE, 64: keystream bits collected; range 1..1024.
- INIT_ROUNDS, 1152: warm-up clock cycles after load. 0 is legal and skips warm-up.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset; driven by the controller's UUT reset.
- key_i  in  80  key; K1 = key_i[0] … K80 = key_i[79].
- iv_i  in  80  IV; IV1 = iv_i[0] … IV80 = iv_i[79].
- keystream_o  out  OUTPUT_SIZE  collected keystream; first bit z1 ends in the MSB.
- end_o  out  1  high once keystream_o is final; connects to the controller's end_uut.

## Operation
- FSM states, in order: LOAD, INIT, GEN, DONE.
- LOAD (reset state), one cycle:
  - (s1..s93) = (K1..K80, 13×0).
  - (s94..s177) = (IV1..IV80, 4×0).
  - (s178..s288) = (108×0, 1, 1, 1).
  - Round counter cleared.
  - Next state INIT, or GEN when INIT_ROUNDS = 0.
- Round function, applied every cycle in INIT and GEN:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288.
  - z = t1^t2^t3.
  - t1 ^= s91&s92 ^ s171; t2 ^= s175&s176 ^ s264; t3 ^= s286&s287 ^ s69.
  - Shift: s1←t3, s94←t1, s178←t2; every other bit moves up one position within its register.
- INIT: runs INIT_ROUNDS cycles, discards z, then goes to GEN.
- GEN: runs OUTPUT_SIZE cycles. Each cycle keystream_o ← {keystream_o[OUTPUT_SIZE-2:0], z}. Then goes to DONE.
- DONE:
  - Cipher state frozen, keystream_o held, end_o = 1.
  - Stays in DONE until rst.
- Round counter width = $clog2(max(INIT_ROUNDS, OUTPUT_SIZE) + 1). Counts 0..N-1 in each phase and wraps to 0 on each phase change.
- key_i and iv_i are sampled only in LOAD; later changes are ignored.

## Timing
- Reset values: keystream_o = 0, end_o = 0, state = LOAD, cipher state = 0, counter = 0.
- Edges are counted from the first rising clk edge with rst low, numbered edge 1.
- Edge 1 performs the LOAD. Edges 2..INIT_ROUNDS+1 perform INIT.
- The next OUTPUT_SIZE edges perform GEN.
- end_o rises registered on edge 1+INIT_ROUNDS+OUTPUT_SIZE; this is edge 1217 with the defaults.
- keystream_o is final on that same edge and stable for as long as end_o is high.
- During GEN, keystream_o shows a partial word; consumers must gate on end_o.
- rst asserted at any point, including mid-INIT or mid-GEN:
  - All registers clear asynchronously and end_o drops at once.
  - After release, a full LOAD/INIT/GEN sequence restarts.
- No handshake exists beyond rst/end_o; a repeat run requires a new reset pulse.

## Configuration
- Macro TRIVIUM_UUT_CYCLE_CNT_EN.
- Defined:
  - Adds output port cycle_cnt_o (32 bits).
  - Reset to 0; increments every cycle from LOAD through the last GEN cycle inclusive.
  - Frozen in DONE; with the defaults it ends at 1217.
  - Used for on-board latency checks through the debug bus.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package trivium_pkg holds:
  - STATE_W = 288, KEY_W = 80, IV_W = 80.
  - The tap-index localparams (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69).
  - The FSM enum type: LOAD, INIT, GEN, DONE.
- Sub-module trivium_core:
  - Holds the 288-bit state register with load and enable inputs.
  - Outputs z combinationally from the current state.
- Top level holds the FSM, round counter, output shift register and optional cycle counter.

## Test plan
- INIT_ROUNDS=0, key=0, iv=0, release rst → keystream_o[63:60] = 4'hE, and end_o rises on edge 65.
- Defaults, key=0, iv=0 → end_o first high on edge 1217, never before; keystream_o equals the bit-level C model (same bit mapping); value held for 100 further cycles.
- Defaults, key and iv changed at edge 10 → result identical to the run with the original key and iv.
- rst pulsed at edge 600 (mid-INIT), then released → end_o low immediately; next rise 1217 edges after release; correct word.
- Random key/iv, 50 runs → every word matches the C model.
- With TRIVIUM_UUT_CYCLE_CNT_EN defined → cycle_cnt_o = 1217 at end_o rise and unchanged 20 cycles later.
